// File: rtl/jt51_phrom_pkg.sv
// Shared widths and types for the phase/sine ROM and the requesters that share it.
package jt51_phrom_pkg;
  localparam int PH_AW    = 5;
  localparam int PH_DW    = 46;
  localparam int DEF_NREQ = 4;

  typedef logic [PH_AW-1:0] ph_addr_t;
  typedef logic [PH_DW-1:0] ph_data_t;
endpackage

// File: rtl/jt51_rr_pick.sv
// Combinational round-robin pick: first asserted req at or above ptr, wrapping.
module jt51_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IDW-1:0]  win_idx,
  output logic            win_vld
);

  int             pos;
  logic [IDW-1:0] idx;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    pos     = 0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      idx = IDW'(pos);
      if (!win_vld && req[idx]) begin
        win_vld     = 1'b1;
        win_oh[idx] = 1'b1;
        win_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/jt51_phrom_arb.sv
// Arbitrates NREQ requesters onto the shared phase ROM; response 1 clk after grant.
// JT51_PHROM_ARB_PRIO_EN: requester 0 has fixed priority, the rest round-robin.
module jt51_phrom_arb
  import jt51_phrom_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cen,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*PH_AW-1:0] req_addr,
  output logic [NREQ-1:0]       gnt,
  output ph_addr_t              rom_addr,
  input  ph_data_t              rom_ph,
  output logic                  rsp_vld,
  output logic [IDW-1:0]        rsp_id,
  output ph_data_t              rsp_ph
);

  logic [IDW-1:0]  ptr_q, ptr_d;
  ph_addr_t        rom_addr_q, rom_addr_d;
  logic            rsp_vld_q, rsp_vld_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;

  logic [NREQ-1:0] rr_req, rr_oh;
  logic [IDW-1:0]  rr_idx;
  logic            rr_vld;
  logic [NREQ-1:0] win_oh;
  logic [IDW-1:0]  win_idx;
  logic            win_any;
  logic            grant;
  ph_addr_t        sel_addr;

  jt51_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req     (rr_req),
    .ptr     (ptr_q),
    .win_oh  (rr_oh),
    .win_idx (rr_idx),
    .win_vld (rr_vld)
  );

`ifdef JT51_PHROM_ARB_PRIO_EN
  // Requester 0 is masked out of the rotation and overrides it when present.
  assign rr_req = {req[NREQ-1:1], 1'b0};

  always_comb begin
    win_oh  = rr_oh;
    win_idx = rr_idx;
    win_any = rr_vld;
    if (req[0]) begin
      win_oh  = {{(NREQ-1){1'b0}}, 1'b1};
      win_idx = '0;
      win_any = 1'b1;
    end
  end
`else
  assign rr_req  = req;
  assign win_oh  = rr_oh;
  assign win_idx = rr_idx;
  assign win_any = rr_vld;
`endif

  assign grant = cen & win_any & ~rst;

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) sel_addr = req_addr[i*PH_AW +: PH_AW];
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    rom_addr_d = rom_addr_q;
    rsp_vld_d  = grant;
    rsp_id_d   = rsp_id_q;
    gnt        = '0;
    rom_addr   = rom_addr_q;
    if (grant) begin
      gnt        = win_oh;
      rom_addr_d = sel_addr;
      rom_addr   = sel_addr;
      rsp_id_d   = win_idx;
`ifdef JT51_PHROM_ARB_PRIO_EN
      // Priority grants to requester 0 leave the rotation where it was.
      if (win_idx != '0)
        ptr_d = (int'(win_idx) == NREQ-1) ? IDW'(1) : win_idx + 1'b1;
`else
      ptr_d = (int'(win_idx) == NREQ-1) ? '0 : win_idx + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      rom_addr_q <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_id_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rom_addr_q <= rom_addr_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  // A response already in flight is suppressed in the reset cycle itself.
  assign rsp_vld = rsp_vld_q & ~rst;
  assign rsp_id  = rsp_id_q;
  assign rsp_ph  = rom_ph;

endmodule

// File: tb/tb_jt51_phrom_arb.sv
// Directed bench for jt51_phrom_arb with a registered ROM model; default or priority build.
module tb_jt51_phrom_arb;
  import jt51_phrom_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic [3:0]  req;
  logic [19:0] req_addr;
  logic [3:0]  gnt;
  ph_addr_t    rom_addr;
  ph_data_t    rom_ph = '0;
  logic        rsp_vld;
  logic [1:0]  rsp_id;
  ph_data_t    rsp_ph;

  ph_addr_t a[4];
  int exp2[5];
  int exp5a[3];
  int exp5b[4];
  int prev;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic ph_data_t rom_val(input ph_addr_t x);
    return {x, x, x, x, x, x, x, x, x, 1'b1};
  endfunction

  always @(posedge clk) if (cen) rom_ph <= rom_val(rom_addr);

  jt51_phrom_arb #(.NREQ(4), .IDW(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .req      (req),
    .req_addr (req_addr),
    .gnt      (gnt),
    .rom_addr (rom_addr),
    .rom_ph   (rom_ph),
    .rsp_vld  (rsp_vld),
    .rsp_id   (rsp_id),
    .rsp_ph   (rsp_ph)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic vld, input int id, input ph_addr_t addr);
    chk({tag, "_vld"}, 64'(rsp_vld), 64'(vld));
    if (vld) begin
      chk({tag, "_id"}, 64'(rsp_id), 64'(id));
      chk({tag, "_ph"}, 64'(rsp_ph), 64'(rom_val(addr)));
    end
  endtask

  task automatic drive(input logic c, input logic r, input logic [3:0] q);
    cen      = c;
    rst      = r;
    req      = q;
    req_addr = {a[3], a[2], a[1], a[0]};
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    a = '{5'd3, 5'd7, 5'd12, 5'd31};
`ifdef JT51_PHROM_ARB_PRIO_EN
    exp2  = '{0, 0, 0, 0, 0};
    exp5a = '{0, 0, 0};
`else
    exp2  = '{0, 1, 2, 3, 0};
    exp5a = '{1, 3, 0};
`endif
    exp5b = '{1, 3, 1, 3};

    // Reset held with all requesters asking: nothing is granted.
    drive(1'b1, 1'b1, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_vld", 64'(rsp_vld), 64'd0);
      chk("rst_addr", 64'(rom_addr), 64'd0);
      chk("rst_id", 64'(rsp_id), 64'd0);
      step();
    end

    // All requesting every cen cycle.
    drive(1'b1, 1'b0, 4'b1111);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_gnt", 64'(gnt), 64'(4'b0001 << exp2[k]));
      chk("rr_addr", 64'(rom_addr), 64'(a[exp2[k]]));
      if (k == 0) chk_rsp("rr_rsp0", 1'b0, 0, '0);
      else        chk_rsp("rr_rsp", 1'b1, exp2[k-1], a[exp2[k-1]]);
      step();
    end

    // Single requester, cen every other cycle.
    a[2] = 5'd20;
    drive(1'b1, 1'b0, 4'b0100);
    @(negedge clk);
    chk("cen_gnt0", 64'(gnt), 64'b0100);
    chk("cen_addr0", 64'(rom_addr), 64'd20);
    chk_rsp("cen_rsp0", 1'b1, exp2[4], a[exp2[4]]);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 4'b0100);
      @(negedge clk);
      chk("cen_off_gnt", 64'(gnt), 64'd0);
      chk("cen_off_addr", 64'(rom_addr), 64'd20);
      chk_rsp("cen_off_rsp", 1'b1, 2, 5'd20);
      step();
      drive(1'b1, 1'b0, 4'b0100);
      @(negedge clk);
      chk("cen_on_gnt", 64'(gnt), 64'b0100);
      chk("cen_on_vld", 64'(rsp_vld), 64'd0);
      chk("cen_on_ph", 64'(rsp_ph), 64'(rom_val(5'd20)));
      step();
    end

    // Grant to requester 1, then reset before its response appears.
    drive(1'b1, 1'b0, 4'b0010);
    @(negedge clk);
    chk("r4_gnt", 64'(gnt), 64'b0010);
    chk("r4_addr", 64'(rom_addr), 64'd7);
    chk_rsp("r4_rsp", 1'b1, 2, 5'd20);
    step();
    drive(1'b1, 1'b1, 4'b1111);
    @(negedge clk);
    chk("r4_rst_gnt", 64'(gnt), 64'd0);
    chk("r4_rst_vld", 64'(rsp_vld), 64'd0);
    step();
    drive(1'b1, 1'b0, 4'b1111);
    @(negedge clk);
    chk("r4_ptr0_gnt", 64'(gnt), 64'b0001);
    chk("r4_rel_vld", 64'(rsp_vld), 64'd0);
    chk("r4_rel_id", 64'(rsp_id), 64'd0);
    step();

    // Requester 0 plus 1 and 3, then requester 0 drops out.
    a[2] = 5'd12;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 4'b1011);
      @(negedge clk);
      chk("p5a_gnt", 64'(gnt), 64'(4'b0001 << exp5a[k]));
      chk("p5a_addr", 64'(rom_addr), 64'(a[exp5a[k]]));
      chk_rsp("p5a_rsp", 1'b1, prev, a[prev]);
      prev = exp5a[k];
      step();
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 4'b1010);
      @(negedge clk);
      chk("p5b_gnt", 64'(gnt), 64'(4'b0001 << exp5b[k]));
      chk("p5b_addr", 64'(rom_addr), 64'(a[exp5b[k]]));
      chk_rsp("p5b_rsp", 1'b1, prev, a[prev]);
      prev = exp5b[k];
      step();
    end

    // Idle: addresses change underneath, rom_addr must hold the last granted one.
    a = '{5'd0, 5'd0, 5'd0, 5'd0};
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 4'b0000);
      @(negedge clk);
      chk("idle_gnt", 64'(gnt), 64'd0);
      chk("idle_addr", 64'(rom_addr), 64'd31);
      chk_rsp("idle_rsp", (i == 0), prev, 5'd31);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
